// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter for a shared FIFO: bursts are granted alternately with no idle bubble on handover.
// Define ARB_BURST_LIMIT_EN to end a burst after MAX_BURST acked beats.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  last0,
   input  logic                  last1,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] din1,
   output logic                  ack0,
   output logic                  ack1,
   input  logic                  fifo_full,
   output logic                  fifo_wr,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   output logic [1:0]            gnt,
   output logic [15:0]           beats_total
);

   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
      $error("fifo_wr_arbiter: MAX_BURST must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic [15:0] beats_q, beats_d;
   logic        cur_req, cur_ack, cur_last;
   logic        limit_hit;
   logic        burst_end;

   always_comb begin
      gnt = 2'b00;
      case (state_q)
         GNT0:    gnt = 2'b01;
         GNT1:    gnt = 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Reset also masks acks so nothing is written while the state is being cleared.
   assign ack0       = gnt[0] & req0 & ~fifo_full & ~reset;
   assign ack1       = gnt[1] & req1 & ~fifo_full & ~reset;
   assign fifo_wr    = ack0 | ack1;
   assign fifo_wdata = gnt[1] ? din1 : din0;

   assign cur_req  = gnt[1] ? req1  : req0;
   assign cur_ack  = ack0 | ack1;
   assign cur_last = gnt[1] ? last1 : last0;

`ifdef ARB_BURST_LIMIT_EN
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   logic [7:0] bcnt_q, bcnt_d;

   assign limit_hit = cur_ack && (bcnt_q == BURST_LAST);

   always_comb begin
      bcnt_d = bcnt_q;
      if (burst_end || state_q == IDLE) begin
         bcnt_d = 8'd0;
      end else if (cur_ack) begin
         bcnt_d = bcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt_q <= 8'd0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end
`else
   assign limit_hit = 1'b0;
`endif

   // An abandoned request ends the burst just like an acked last beat.
   assign burst_end = (state_q != IDLE) &&
                      (~cur_req || (cur_ack && cur_last) || limit_hit);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      beats_d = beats_q + {15'd0, fifo_wr};
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || !ptr_q)) begin
               state_d = GNT0;
            end else if (req1) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (burst_end) begin
               ptr_d   = 1'b1;
               state_d = req1 ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (burst_end) begin
               ptr_d   = 1'b0;
               state_d = req0 ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         beats_q <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         beats_q <= beats_d;
      end
   end

   assign beats_total = beats_q;

endmodule
